// File: rtl/dsram_axi_bridge_pkg.sv
//------------------------------------------------------------------------------
// dsram_axi_bridge_pkg: FSM encoding and AXI constants for the data-side bridge.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dsram_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_AR  = 3'd1,
    ST_RD_R   = 3'd2,
    ST_WR_AWW = 3'd3,
    ST_WR_B   = 3'd4
  } state_t;

  localparam logic [7:0] LEN0       = 8'd0;
  localparam logic [1:0] BURST_INCR = 2'b01;

  // SRAM size code (0/1/2) is already log2(bytes), so AxSIZE is a zero-extension.
  function automatic logic [2:0] to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dsram_axi_bridge_if.sv
//------------------------------------------------------------------------------
// dsram_axi_bridge_if: SRAM-like request side plus single-beat AXI channels.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dsram_axi_bridge_if;

  logic        data_sram_req_i;
  logic        data_sram_wr_i;
  logic [1:0]  data_sram_size_i;
  logic [3:0]  data_sram_wstrb_i;
  logic [31:0] data_sram_addr_i;
  logic [31:0] data_sram_wdata_i;
  logic        data_sram_addr_ok_o;
  logic        data_sram_data_ok_o;
  logic [31:0] data_sram_rdata_o;

  logic [3:0]  arid_o;
  logic [31:0] araddr_o;
  logic [2:0]  arsize_o;
  logic        arvalid_o;
  logic        arready_i;

  logic [3:0]  rid_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;
  logic        rvalid_i;
  logic        rready_o;

  logic [3:0]  awid_o;
  logic [31:0] awaddr_o;
  logic [2:0]  awsize_o;
  logic        awvalid_o;
  logic        awready_i;

  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast_o;
  logic        wvalid_o;
  logic        wready_i;

  logic [3:0]  bid_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i;
  logic        bready_o;

  // Bridge view: responder to the MEM stage, AXI master toward the crossbar.
  modport master (
    input  data_sram_req_i, data_sram_wr_i, data_sram_size_i, data_sram_wstrb_i,
           data_sram_addr_i, data_sram_wdata_i,
    output data_sram_addr_ok_o, data_sram_data_ok_o, data_sram_rdata_o,
    output arid_o, araddr_o, arsize_o, arvalid_o,
    input  arready_i,
    input  rid_i, rdata_i, rresp_i, rlast_i, rvalid_i,
    output rready_o,
    output awid_o, awaddr_o, awsize_o, awvalid_o,
    input  awready_i,
    output wdata_o, wstrb_o, wlast_o, wvalid_o,
    input  wready_i,
    input  bid_i, bresp_i, bvalid_i,
    output bready_o
  );

  // Environment view: MEM stage requester and AXI slave.
  modport slave (
    output data_sram_req_i, data_sram_wr_i, data_sram_size_i, data_sram_wstrb_i,
           data_sram_addr_i, data_sram_wdata_i,
    input  data_sram_addr_ok_o, data_sram_data_ok_o, data_sram_rdata_o,
    input  arid_o, araddr_o, arsize_o, arvalid_o,
    output arready_i,
    output rid_i, rdata_i, rresp_i, rlast_i, rvalid_i,
    input  rready_o,
    input  awid_o, awaddr_o, awsize_o, awvalid_o,
    output awready_i,
    input  wdata_o, wstrb_o, wlast_o, wvalid_o,
    output wready_i,
    output bid_i, bresp_i, bvalid_i,
    input  bready_o
  );

endinterface

`default_nettype wire

// File: rtl/dsram_axi_bridge_wr_issue.sv
//------------------------------------------------------------------------------
// dsram_axi_bridge_wr_issue: drives AW and W valids, completing each independently.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dsram_axi_bridge_wr_issue (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic done
);

  logic aw_done;
  logic w_done;
  logic aw_hs;
  logic w_hs;

  assign awvalid = active & ~aw_done;
  assign wvalid  = active & ~w_done;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  // A handshake landing this cycle counts, so the final one needs no extra cycle.
  assign done    = active & (aw_done | aw_hs) & (w_done | w_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (done) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dsram_axi_bridge.sv
//------------------------------------------------------------------------------
// dsram_axi_bridge: turns each data-SRAM request into one single-beat AXI4 transfer.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dsram_axi_bridge
  import dsram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] RD_ID = 4'd1,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dsram_axi_bridge_if.master   bus
);

  state_t      state_q;
  state_t      state_d;

  logic        req_wr_q;
  logic [1:0]  req_size_q;
  logic [3:0]  req_wstrb_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [31:0] rdata_q;
  logic        data_ok_q;

  logic        accept;
  logic        ar_valid;
  logic        r_ready;
  logic        b_ready;
  logic        r_fire;
  logic        b_fire;
  logic        wr_active;
  logic        wr_aw_valid;
  logic        wr_w_valid;
  logic        wr_done;
  logic        unused_axi_fields;

  // Gated with reset so no request is acknowledged while the bridge is held.
  assign accept = rst_n & (state_q == ST_IDLE) & bus.data_sram_req_i;
  assign r_fire = r_ready & bus.rvalid_i;
  assign b_fire = b_ready & bus.bvalid_i;
  assign wr_active = (state_q == ST_WR_AWW);

  always_comb begin
    state_d  = state_q;
    ar_valid = 1'b0;
    r_ready  = 1'b0;
    b_ready  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.data_sram_req_i) state_d = bus.data_sram_wr_i ? ST_WR_AWW : ST_RD_AR;
      end
      ST_RD_AR: begin
        ar_valid = 1'b1;
        if (bus.arready_i) state_d = ST_RD_R;
      end
      ST_RD_R: begin
        r_ready = 1'b1;
        if (bus.rvalid_i) state_d = ST_IDLE;
      end
      ST_WR_AWW: begin
        if (wr_done) state_d = ST_WR_B;
      end
      ST_WR_B: begin
        b_ready = 1'b1;
        if (bus.bvalid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_wr_q    <= 1'b0;
      req_size_q  <= 2'd0;
      req_wstrb_q <= 4'd0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
    end else if (accept) begin
      req_wr_q    <= bus.data_sram_wr_i;
      req_size_q  <= bus.data_sram_size_i;
      req_wstrb_q <= bus.data_sram_wstrb_i;
      req_addr_q  <= bus.data_sram_addr_i;
      req_wdata_q <= bus.data_sram_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q   <= 32'd0;
      data_ok_q <= 1'b0;
    end else begin
      data_ok_q <= r_fire | b_fire;
      if (r_fire) rdata_q <= bus.rdata_i;
    end
  end

  dsram_axi_bridge_wr_issue u_wr_issue (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (wr_active),
    .awready (bus.awready_i),
    .wready  (bus.wready_i),
    .awvalid (wr_aw_valid),
    .wvalid  (wr_w_valid),
    .done    (wr_done)
  );

  assign bus.data_sram_addr_ok_o = accept;
  assign bus.data_sram_data_ok_o = data_ok_q;
  assign bus.data_sram_rdata_o   = rdata_q;

  assign bus.arid_o    = RD_ID;
  assign bus.araddr_o  = req_addr_q;
  assign bus.arsize_o  = to_axsize(req_size_q);
  assign bus.arvalid_o = ar_valid;
  assign bus.rready_o  = r_ready;

  assign bus.awid_o    = WR_ID;
  assign bus.awaddr_o  = req_addr_q;
  assign bus.awsize_o  = to_axsize(req_size_q);
  assign bus.awvalid_o = wr_aw_valid;

  assign bus.wdata_o   = req_wdata_q;
  assign bus.wstrb_o   = req_wstrb_q;
  assign bus.wlast_o   = wr_w_valid;
  assign bus.wvalid_o  = wr_w_valid;
  assign bus.bready_o  = b_ready;

  // Response ids/status are not checked; the latched wr bit is informational only.
  assign unused_axi_fields = ^{bus.rid_i, bus.rresp_i, bus.rlast_i,
                               bus.bid_i, bus.bresp_i, req_wr_q};

endmodule

`default_nettype wire

// File: doc/dsram_axi_bridge.md
Name: dsram_axi_bridge

Overview:
- Responder end of the data-side SRAM-like interface (req / addr_ok / data_ok / rdata) that the MEM stage drives. It converts each accepted data request into one AXI4 single-beat transaction: AR+R for loads, AW+W+B for stores.
- Sits between the execute-side request generator / MEM stage and the top-level AXI crossbar.
- One transaction outstanding at a time.

Parameters:
- RD_ID, 4'd1, ARID driven on reads
- WR_ID, 4'd1, AWID driven on writes

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- data_sram_req_i  in  1  request valid
- data_sram_wr_i  in  1  1=store, 0=load
- data_sram_size_i  in  2  0=byte, 1=half, 2=word
- data_sram_wstrb_i  in  4  byte enables (stores)
- data_sram_addr_i  in  32  byte address
- data_sram_wdata_i  in  32  store data
- data_sram_addr_ok_o  out  1  request accepted this cycle
- data_sram_data_ok_o  out  1  one-cycle completion pulse
- data_sram_rdata_o  out  32  load data, valid with data_ok
- arid_o / araddr_o / arsize_o / arvalid_o  out  4/32/3/1  read address channel
- arready_i  in  1
- rid_i / rdata_i / rresp_i / rlast_i / rvalid_i  in  4/32/2/1/1  read data channel
- rready_o  out  1
- awid_o / awaddr_o / awsize_o / awvalid_o  out  4/32/3/1  write address channel
- awready_i  in  1
- wdata_o / wstrb_o / wlast_o / wvalid_o  out  32/4/1/1  write data channel
- wready_i  in  1
- bid_i / bresp_i / bvalid_i  in  4/2/1  write response channel
- bready_o  out  1
- Constant AXI fields (len=0, burst=INCR, lock/cache/prot=0, wid=WR_ID) are tied at top level; they are not ports.

Behaviour:
- FSM states:
  - IDLE
  - RD_AR
  - RD_R
  - WR_AWW
  - WR_B
- IDLE:
  - addr_ok_o = req_i, combinational; asserts only in IDLE.
  - On req_i, latch wr, size, wstrb, addr and wdata into request registers.
  - Next state is WR_AWW if wr, else RD_AR.
- RD_AR:
  - arvalid_o=1, araddr_o=latched addr, arsize_o={1'b0,size}, arid_o=RD_ID.
  - Leave on arready_i to RD_R; arvalid_o drops the following cycle.
- RD_R:
  - rready_o=1.
  - On rvalid_i: register rdata_i into data_sram_rdata_o, go to IDLE, and pulse data_ok_o for exactly the next cycle.
  - rid, rresp and rlast are not checked.
- WR_AWW:
  - awvalid_o and wvalid_o are each asserted until their own handshake; the two handshakes complete independently, in either order or the same cycle.
  - Track them with aw_done / w_done flags.
  - wlast_o=1 whenever wvalid_o. wstrb_o and wdata_o come from the latched values; awsize_o={1'b0,size}.
  - Go to WR_B once both flags are set, counting a handshake in the current cycle.
- WR_B:
  - bready_o=1.
  - On bvalid_i, go to IDLE and pulse data_ok_o the next cycle; bresp is ignored.
- data_ok_o / rdata_o:
  - data_ok_o is registered and is high for exactly one cycle per accepted request.
  - It may coincide with addr_ok_o for the next request, since the FSM is already in IDLE.
  - data_sram_rdata_o holds its value until the next load completes; it is undefined for stores (holds old value).
- Latched request registers change only on an addr_ok handshake. Inputs may change freely after acceptance.
- No flush input: every accepted request completes. Cancellation is the consumer's responsibility via its valid bit.
- Reset (asynchronous, any state, including mid-handshake):
  - FSM goes to IDLE.
  - All valid/ready/ok outputs = 0.
  - rdata_o = 0, aw_done = w_done = 0.
  - Address/data registers = 0.
- AXI valid signals never drop before their handshake.

Decomposition:
- Shared package/header: FSM state encodings, AXI constant field values (LEN0, BURST_INCR), and the size-to-axsize mapping.
- Natural single sub-module: none required. The optional aw/w dual-handshake tracker can be split as axi_wr_issue if reused by the instruction-side bridge.

Test Plan:
- Load: req=1, wr=0, addr=0x1c000104, size=2 → addr_ok same cycle; AR with araddr=0x1c000104, arsize=2; rdata=0xDEADBEEF with rvalid after 3 stall cycles → data_ok one cycle later with rdata_o=0xDEADBEEF.
- Store with awready before wready: addr=0x80, wstrb=4'b0011, wdata=0x1234 → AW handshake at T, W at T+2, awvalid low after T; bvalid at T+4 → data_ok at T+5, exactly 1 cycle.
- Store with simultaneous AW/W handshake in the first WR_AWW cycle → direct move to WR_B; no duplicate handshake.
- Back-to-back: req held high across two loads → second addr_ok coincides with first data_ok; both rdata values correct and in order.
- Backpressure: arready=0 for 10 cycles → arvalid stable at 1, araddr stable, addr_ok stays 0 for new reqs.
- Reset asserted mid-RD_R (rvalid pending) → all outputs 0 immediately; after release, a new load completes normally and no stray data_ok appears.
